// File: rtl/div_unit.sv
// div_unit: iterative restoring divider for DIV.W/DIV.WU/MOD.W/MOD.WU.
// It holds its result for as long as the execute stage keeps presenting the same request.
module div_unit #(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [66:0] es_to_div_bus,
    output logic [32:0] div_to_es_bus
);
    typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;
    state_t      state;
    logic [65:0] key_r;
    logic [5:0]  count, count_nxt;
    logic [31:0] rem, quo, dvs, result_r;
    logic        neg_q, neg_r;
    logic        en, is_signed, div_ok, div_zero;
    logic [65:0] key;
    logic [31:0] src1, src2, mag1, mag2, q_fix, r_fix, rem_c, quo_c;
    logic [32:0] sh;
    logic        ge;
    assign en        = es_to_div_bus[66];
    assign key       = es_to_div_bus[65:0];
    assign src1      = key[63:32];
    assign src2      = key[31:0];
    assign is_signed = ~key[64];
    assign mag1      = is_signed && src1[31] ? -src1 : src1;
    assign mag2      = is_signed && src2[31] ? -src2 : src2;
    assign count_nxt = count + 6'(STEPS_PER_CYCLE);
    always_comb begin
        rem_c = rem;
        quo_c = quo;
        sh    = '0;
        ge    = 1'b0;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            sh    = {rem_c, quo_c[31]};
            ge    = sh >= {1'b0, dvs};
            quo_c = {quo_c[30:0], ge};
            rem_c = ge ? 32'(sh - {1'b0, dvs}) : sh[31:0];
        end
    end
    // Divide by zero bypasses the sign fix-up: all-ones quotient, raw dividend as remainder.
    assign div_zero = key_r[31:0] == 32'd0;
    assign q_fix    = div_zero ? 32'hFFFF_FFFF : neg_q ? -quo : quo;
    assign r_fix    = div_zero ? key_r[63:32] : neg_r ? -rem : rem;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            key_r    <= '0;
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_r <= '0;
        end else if (!en) begin
            state <= IDLE;
            count <= '0;
        end else if (state == IDLE || key != key_r) begin
            key_r <= key;
            count <= '0;
            rem   <= '0;
            quo   <= mag1;
            dvs   <= mag2;
            neg_q <= is_signed & (src1[31] ^ src2[31]);
            neg_r <= is_signed & src1[31];
            state <= src2 == 32'd0 ? FIX : BUSY;
        end else begin
            case (state)
                BUSY: begin
                    rem   <= rem_c;
                    quo   <= quo_c;
                    count <= count_nxt;
                    state <= count_nxt == 6'd32 ? FIX : BUSY;
                end
                FIX: begin
                    result_r <= key_r[65] ? r_fix : q_fix;
                    state    <= DONE;
                end
                default: state <= state;
            endcase
        end
    end
    assign div_ok        = state == DONE && en && key == key_r;
    assign div_to_es_bus = {div_ok ? result_r : 32'd0, div_ok};
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: drives div_unit with STEPS_PER_CYCLE 1, 2 and 4 from one request bus and
// checks every cycle against an arithmetic golden model plus directed latency checks.
module tb_div_unit;
    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [65:0] key;
    logic [66:0] bus;
    logic [32:0] o [3];
    int          stp [3] = '{1, 2, 4};
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          have = 1'b0;
    logic [65:0] mkey = '0;
    int          t0 = 0;
    bit          okx;
    logic [31:0] ra, rb;
    int          sel, hold;
    logic [65:0] rk;

    assign bus = {en, key};
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_unit #(.STEPS_PER_CYCLE(1)) u1 (.clk(clk), .resetn(resetn), .es_to_div_bus(bus), .div_to_es_bus(o[0]));
    div_unit #(.STEPS_PER_CYCLE(2)) u2 (.clk(clk), .resetn(resetn), .es_to_div_bus(bus), .div_to_es_bus(o[1]));
    div_unit #(.STEPS_PER_CYCLE(4)) u4 (.clk(clk), .resetn(resetn), .es_to_div_bus(bus), .div_to_es_bus(o[2]));

    function automatic logic [65:0] mk(bit m, bit u, logic [31:0] a, logic [31:0] b);
        return {m, u, a, b};
    endfunction

    function automatic logic [31:0] golden(logic [65:0] k);
        logic [31:0] a, b, q, r;
        a = k[63:32];
        b = k[31:0];
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (k[64]) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = 0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return k[65] ? r : q;
    endfunction

    function automatic int lat(int s, logic [65:0] k);
        return k[31:0] == 0 ? 2 : 32 / stp[s] + 2;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // Cycle model: a request is accepted when idle or when the key changes, and the
    // answer appears lat cycles later and stays while en and the key are held.
    always @(negedge clk) begin
        if (cyc > 0) begin
            for (int s = 0; s < 3; s++) begin
                okx = en && have && key == mkey && (cyc - t0) >= lat(s, mkey);
                chk($sformatf("cyc%0d_s%0d", cyc, stp[s]), 64'(o[s]), 64'({okx ? golden(mkey) : 32'd0, okx}));
            end
            if (!resetn || !en) have = 1'b0;
            else if (!have || key != mkey) begin
                have = 1'b1;
                mkey = key;
                t0   = cyc;
            end
        end
    end

    task automatic drive(input bit e, input logic [65:0] k);
        @(posedge clk);
        #1;
        en  = e;
        key = k;
    endtask

    task automatic expect_req(input string nm, input logic [31:0] res);
        int          t;
        int          first [3];
        logic [31:0] got [3];
        t = cyc;
        for (int s = 0; s < 3; s++) begin
            first[s] = -1;
            got[s]   = '0;
        end
        repeat (40) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++)
                if (first[s] < 0 && o[s][0]) begin
                    first[s] = cyc;
                    got[s]   = o[s][32:1];
                end
        end
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("%s_lat_s%0d", nm, stp[s]), 64'(first[s]), 64'(t + lat(s, key)));
            chk($sformatf("%s_res_s%0d", nm, stp[s]), 64'(got[s]), 64'(res));
            chk($sformatf("%s_hold_s%0d", nm, stp[s]), 64'(o[s]), 64'({res, 1'b1}));
        end
    endtask

    task automatic expect_silent(input string nm, input int n);
        bit seen;
        seen = 1'b0;
        repeat (n) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) seen |= o[s][0];
        end
        chk(nm, 64'(seen), 64'd0);
    endtask

    initial begin
        resetn = 1'b0;
        en     = 1'b0;
        key    = '0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        chk("model_100_7", 64'(golden(mk(0, 1, 100, 7))), 64'd14);
        chk("model_smod", 64'(golden(mk(1, 0, 32'hFFFF_FFF9, 2))), 64'hFFFF_FFFF);
        chk("model_sdiv", 64'(golden(mk(0, 0, 32'hFFFF_FFF9, 2))), 64'hFFFF_FFFD);
        chk("model_ovf", 64'(golden(mk(0, 0, 32'h8000_0000, 32'hFFFF_FFFF))), 64'h8000_0000);
        chk("model_dz_mod", 64'(golden(mk(1, 0, 32'h1234, 0))), 64'h1234);
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk($sformatf("reset_s%0d", stp[s]), 64'(o[s]), 64'd0);

        drive(1, mk(0, 1, 100, 7));
        expect_req("udiv", 14);
        drive(0, '0);
        drive(1, mk(1, 0, 32'hFFFF_FFF9, 2));
        expect_req("smod", 32'hFFFF_FFFF);
        drive(1, mk(0, 0, 32'hFFFF_FFF9, 2));
        expect_req("sdiv", 32'hFFFF_FFFD);
        drive(1, mk(0, 0, 32'h1234, 0));
        expect_req("dz_div", 32'hFFFF_FFFF);
        drive(1, mk(1, 1, 32'h1234, 0));
        expect_req("dz_mod", 32'h1234);
        drive(1, mk(0, 0, 32'h8000_0000, 32'hFFFF_FFFF));
        expect_req("ovf_div", 32'h8000_0000);
        drive(1, mk(1, 0, 32'h8000_0000, 32'hFFFF_FFFF));
        expect_req("ovf_mod", 32'h0);

        drive(0, '0);
        drive(1, mk(0, 1, 1000, 3));
        repeat (9) @(posedge clk);
        drive(0, mk(0, 1, 1000, 3));
        expect_silent("abort_no_ok", 40);

        drive(1, mk(0, 1, 1000, 3));
        repeat (19) @(posedge clk);
        drive(1, mk(1, 0, 32'hFFFF_FC18, 7));
        expect_req("restart", 32'hFFFF_FFFA);

        drive(0, '0);
        drive(1, mk(0, 1, 77, 5));
        repeat (5) @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) chk($sformatf("midbusy_reset_s%0d", stp[s]), 64'(o[s]), 64'd0);

        drive(0, '0);
        drive(1, mk(0, 1, 50, 5));
        expect_req("b2b_first", 10);
        drive(1, mk(0, 1, 81, 9));
        expect_req("b2b_second", 9);

        for (int n = 0; n < 250; n++) begin
            sel = $urandom_range(0, 9);
            ra  = $urandom;
            rb  = $urandom;
            if (sel == 0) rb = 0;
            if (sel == 1) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            if (sel == 2) begin
                ra = $urandom_range(0, 300);
                rb = $urandom_range(1, 20);
                if ($urandom_range(0, 1) == 1) ra = -ra;
                if ($urandom_range(0, 1) == 1) rb = -rb;
            end
            rk = mk($urandom_range(0, 1), sel == 1 ? 0 : $urandom_range(0, 1), ra, rb);
            drive(1, rk);
            hold = $urandom_range(1, 45);
            repeat (hold - 1) @(posedge clk);
            sel = $urandom_range(0, 9);
            if (sel == 0) drive(0, '0);
            if (sel == 1) begin
                @(posedge clk);
                #1 resetn = 1'b0;
                @(posedge clk);
                #1 resetn = 1'b1;
            end
            if (sel == 2) begin
                drive(1, rk);
                repeat (10) @(posedge clk);
            end
        end
        drive(0, '0);
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
